// File: rtl/fwrisc_loader_pkg.sv
`default_nettype none
//============================================================================
// Module  : fwrisc_loader_pkg
// Purpose : Shared types and helpers for the UART program loader: the
//           loader state encoding, the bytes-per-word helper and the default
//           terminator word used in marker framing.
// Ports   : none (package)
// Revision: 1.0 - initial release
//============================================================================
package fwrisc_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_CSUM  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_e;

  localparam logic [31:0] c_default_end_marker = 32'hFFFF_FFFF;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwrisc_loader_packer.sv
`default_nettype none
//============================================================================
// Module  : fwrisc_loader_packer
// Purpose : Assembles a byte stream into DATA_WIDTH words. The completed
//           word is presented combinationally together with the final byte
//           so the caller can register it on the same edge.
// Ports   : clock, rst_n     - clock, asynchronous active-low reset
//           clr_i            - synchronous clear of the byte counter
//           byte_i/valid_i   - incoming byte and its strobe
//           word_o/valid_o   - assembled word, valid with the final byte
// Revision: 1.0 - initial release
//============================================================================
module fwrisc_loader_packer
  import fwrisc_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  word_valid_o
);

  localparam int c_nb = bytes_per_word(DATA_WIDTH);
  localparam int c_cw = (c_nb > 1) ? $clog2(c_nb) : 1;

  logic [c_cw-1:0] r_cnt;
  logic            w_last;

  assign w_last       = (r_cnt == c_cw'(c_nb - 1));
  assign word_valid_o = byte_valid_i & w_last;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (byte_valid_i) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  generate
    if (c_nb == 1) begin : g_single
      assign word_o = byte_i;
    end else begin : g_multi
      // Only the first NB-1 bytes need storage; the last one is taken
      // straight from the input when the word completes.
      logic [DATA_WIDTH-9:0] r_hold;

      if (BIG_ENDIAN) begin : g_big
        logic [DATA_WIDTH-1:0] w_shift;
        assign w_shift = {r_hold, byte_i};
        assign word_o  = w_shift;

        always_ff @(posedge clock or negedge rst_n) begin
          if (!rst_n) begin
            r_hold <= '0;
          end else if (clr_i) begin
            r_hold <= '0;
          end else if (byte_valid_i) begin
            r_hold <= w_shift[DATA_WIDTH-9:0];
          end
        end
      end else begin : g_little
        assign word_o = {byte_i, r_hold};

        always_ff @(posedge clock or negedge rst_n) begin
          if (!rst_n) begin
            r_hold <= '0;
          end else if (clr_i) begin
            r_hold <= '0;
          end else if (byte_valid_i) begin
            for (int i = 0; i < c_nb - 1; i++) begin
              if (r_cnt == c_cw'(i)) r_hold[i*8 +: 8] <= byte_i;
            end
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fwrisc_uart_loader.sv
`default_nettype none
//============================================================================
// Module  : fwrisc_uart_loader
// Purpose : Loads a program image received over a UART byte stream into the
//           instruction TCM. Supports marker framing (ends on a terminator
//           word) and header framing (length word, data, checksum word).
//           done_o gates core instruction fetch.
// Ports   : clock, rst_n        - clock, asynchronous active-low reset
//           byte_i, byte_valid_i - received byte and strobe
//           start_i              - re-arm request (DONE/ERROR only)
//           wr_en_o/addr/data    - ITCM write port
//           loading_o, done_o    - load status
//           overflow_o           - image larger than DEPTH
//           cksum_err_o          - header-mode checksum mismatch
//           word_count_o         - words written in the current load
// Revision: 1.0 - initial release
//============================================================================
module fwrisc_uart_loader
  import fwrisc_loader_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 4096,
  parameter int          ADDR_WIDTH = $clog2(DEPTH),
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter bit          USE_HEADER = 1'b1,
  parameter logic [31:0] END_MARKER = c_default_end_marker
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  input  logic                  start_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  loading_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic                  cksum_err_o,
  output logic [ADDR_WIDTH:0]   word_count_o
);

  // Length comparison is done in a width wide enough for both the received
  // word and DEPTH, so neither side is truncated.
  localparam int                    c_cw     = (DATA_WIDTH > ADDR_WIDTH + 1) ? DATA_WIDTH : ADDR_WIDTH + 1;
  localparam int                    c_cntw   = ADDR_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] c_marker = DATA_WIDTH'(END_MARKER);
  localparam logic [c_cw-1:0]       c_depth  = c_cw'(DEPTH);
  localparam logic [c_cntw-1:0]     c_depthc = c_cntw'(DEPTH);
  localparam loader_state_e         c_init   = USE_HEADER ? ST_LEN : ST_DATA;

  loader_state_e         r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_sum, w_sum_nxt;
  logic [c_cntw-1:0]     r_count, w_count_nxt;
  logic [c_cntw-1:0]     r_len, w_len_nxt;
  logic                  r_wr_en, w_wr_en_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_nxt;
  logic                  r_overflow, w_overflow_nxt;
  logic                  r_cksum_err, w_cksum_err_nxt;
  logic                  r_loading, r_done;
  logic                  w_clr;
  logic                  w_active;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_word_valid;
  logic [c_cw-1:0]       w_word_ext;

  // Bytes arriving in DONE/ERROR never reach the packer, which also makes a
  // simultaneous start/byte pair drop the byte.
  assign w_active   = (r_state != ST_DONE) && (r_state != ST_ERROR);
  assign w_word_ext = c_cw'(w_word);

  fwrisc_loader_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clock        (clock),
    .rst_n        (rst_n),
    .clr_i        (w_clr),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i & w_active),
    .word_o       (w_word),
    .word_valid_o (w_word_valid)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_state <= c_init;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sum_nxt       = r_sum;
    w_count_nxt     = r_count;
    w_len_nxt       = r_len;
    w_wr_en_nxt     = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_overflow_nxt  = r_overflow;
    w_cksum_err_nxt = r_cksum_err;
    w_clr           = 1'b0;

    case (r_state)
      ST_LEN: begin
        if (w_word_valid) begin
          if (w_word_ext > c_depth) begin
            w_state_nxt    = ST_ERROR;
            w_overflow_nxt = 1'b1;
          end else if (w_word == '0) begin
            w_state_nxt = ST_CSUM;
          end else begin
            w_len_nxt   = c_cntw'(w_word_ext);
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_word_valid) begin
          if (!USE_HEADER && (w_word == c_marker)) begin
            w_state_nxt = ST_DONE;
          end else if (!USE_HEADER && (r_count == c_depthc)) begin
            // Image is full and another non-marker word arrived.
            w_state_nxt    = ST_ERROR;
            w_overflow_nxt = 1'b1;
          end else begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = r_count[ADDR_WIDTH-1:0];
            w_wr_data_nxt = w_word;
            w_count_nxt   = r_count + 1'b1;
            w_sum_nxt     = r_sum + w_word;
            if (USE_HEADER && (w_count_nxt == r_len)) w_state_nxt = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (w_word_valid) begin
          if (w_word == r_sum) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt     = ST_ERROR;
            w_cksum_err_nxt = 1'b1;
          end
        end
      end
      ST_DONE, ST_ERROR: begin
        if (start_i) begin
          w_state_nxt     = c_init;
          w_sum_nxt       = '0;
          w_count_nxt     = '0;
          w_len_nxt       = '0;
          w_overflow_nxt  = 1'b0;
          w_cksum_err_nxt = 1'b0;
          w_clr           = 1'b1;
        end
      end
      default: w_state_nxt = c_init;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_count     <= '0;
      r_len       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_overflow  <= 1'b0;
      r_cksum_err <= 1'b0;
      r_loading   <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_sum       <= w_sum_nxt;
      r_count     <= w_count_nxt;
      r_len       <= w_len_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_overflow  <= w_overflow_nxt;
      r_cksum_err <= w_cksum_err_nxt;
      // Status follows the next state so it lands one cycle after the
      // deciding byte, aligned with the error flags.
      r_loading   <= (w_state_nxt != ST_DONE) && (w_state_nxt != ST_ERROR);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  assign wr_en_o      = r_wr_en;
  assign wr_addr_o    = r_wr_addr;
  assign wr_data_o    = r_wr_data;
  assign loading_o    = r_loading;
  assign done_o       = r_done;
  assign overflow_o   = r_overflow;
  assign cksum_err_o  = r_cksum_err;
  assign word_count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fwrisc_uart_loader.sv
`default_nettype none
//============================================================================
// Module  : tb_fwrisc_uart_loader
// Purpose : Self-checking bench for fwrisc_uart_loader. Three instances:
//           0 = 32-bit big-endian header mode, DEPTH 8
//           1 = 32-bit big-endian marker mode, DEPTH 4
//           2 = 16-bit little-endian marker mode, DEPTH 16
// Revision: 1.0 - initial release
//============================================================================
module tb_fwrisc_uart_loader;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] bt [NI];
  logic       bv [NI];
  logic       st [NI];

  wire [NI-1:0]       wen, lod, dn, ov, ce;
  wire [NI-1:0][31:0] wad, wdt, wcn;

  wire [2:0]  h_addr; wire [31:0] h_data; wire [3:0] h_cnt;
  wire [1:0]  m_addr; wire [31:0] m_data; wire [2:0] m_cnt;
  wire [3:0]  l_addr; wire [15:0] l_data; wire [4:0] l_cnt;

  assign wad[0] = {29'd0, h_addr}; assign wdt[0] = h_data;          assign wcn[0] = {28'd0, h_cnt};
  assign wad[1] = {30'd0, m_addr}; assign wdt[1] = m_data;          assign wcn[1] = {29'd0, m_cnt};
  assign wad[2] = {28'd0, l_addr}; assign wdt[2] = {16'd0, l_data}; assign wcn[2] = {27'd0, l_cnt};

  fwrisc_uart_loader #(.DATA_WIDTH(32), .DEPTH(8), .BIG_ENDIAN(1'b1), .USE_HEADER(1'b1)) u_hdr (
    .clock(clk), .rst_n(rst_n), .byte_i(bt[0]), .byte_valid_i(bv[0]), .start_i(st[0]),
    .wr_en_o(wen[0]), .wr_addr_o(h_addr), .wr_data_o(h_data), .loading_o(lod[0]), .done_o(dn[0]),
    .overflow_o(ov[0]), .cksum_err_o(ce[0]), .word_count_o(h_cnt));

  fwrisc_uart_loader #(.DATA_WIDTH(32), .DEPTH(4), .BIG_ENDIAN(1'b1), .USE_HEADER(1'b0)) u_mrk (
    .clock(clk), .rst_n(rst_n), .byte_i(bt[1]), .byte_valid_i(bv[1]), .start_i(st[1]),
    .wr_en_o(wen[1]), .wr_addr_o(m_addr), .wr_data_o(m_data), .loading_o(lod[1]), .done_o(dn[1]),
    .overflow_o(ov[1]), .cksum_err_o(ce[1]), .word_count_o(m_cnt));

  fwrisc_uart_loader #(.DATA_WIDTH(16), .DEPTH(16), .BIG_ENDIAN(1'b0), .USE_HEADER(1'b0)) u_le (
    .clock(clk), .rst_n(rst_n), .byte_i(bt[2]), .byte_valid_i(bv[2]), .start_i(st[2]),
    .wr_en_o(wen[2]), .wr_addr_o(l_addr), .wr_data_o(l_data), .loading_o(lod[2]), .done_o(dn[2]),
    .overflow_o(ov[2]), .cksum_err_o(ce[2]), .word_count_o(l_cnt));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          inst;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t wq[$];

  // Write monitor: one entry per cycle wr_en is high.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (wen[i] === 1'b1) wq.push_back('{i, wad[i], wdt[i]});
    end
  end

  logic [7:0]  stim[$];
  logic [31:0] exp_w[$];
  int          exp_status;
  int          exp_cnt;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] flags_of(input int status);
    case (status)
      1:       return 4'b1000;
      2:       return 4'b0100;
      3:       return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic void push32(input logic [31:0] w);
    stim.push_back(w[31:24]);
    stim.push_back(w[23:16]);
    stim.push_back(w[15:8]);
    stim.push_back(w[7:0]);
  endfunction

  // Transaction-level reference: decode the byte stream into words by
  // arithmetic, then apply the framing rules word by word.
  // Phases: 0 length, 1 data, 2 checksum, 3 done, 4 overflow, 5 checksum error.
  function automatic void model(input int inst);
    int nb, depth, ph, cnt, len;
    bit be, hdr;
    longint unsigned mk, mask, w, sum;
    case (inst)
      0:       begin nb = 4; depth = 8;  be = 1; hdr = 1; mk = 64'h0;        mask = 64'hFFFF_FFFF; end
      1:       begin nb = 4; depth = 4;  be = 1; hdr = 0; mk = 64'hFFFF_FFFF; mask = 64'hFFFF_FFFF; end
      default: begin nb = 2; depth = 16; be = 0; hdr = 0; mk = 64'hFFFF;      mask = 64'hFFFF;      end
    endcase
    exp_w.delete();
    ph = hdr ? 0 : 1; cnt = 0; len = 0; sum = 0;
    for (int k = 0; (k + nb <= stim.size()) && (ph < 3); k += nb) begin
      w = 0;
      for (int j = 0; j < nb; j++) begin
        if (be) w = w * 256 + 64'(stim[k+j]);
        else    w = w + (64'(stim[k+j]) << (8 * j));
      end
      case (ph)
        0: begin
          if (w > 64'(depth)) ph = 4;
          else if (w == 0)    ph = 2;
          else begin len = int'(w); ph = 1; end
        end
        1: begin
          if (!hdr && w == mk)            ph = 3;
          else if (!hdr && cnt == depth)  ph = 4;
          else begin
            exp_w.push_back(32'(w));
            cnt++;
            sum = (sum + w) & mask;
            if (hdr && cnt == len) ph = 2;
          end
        end
        2: ph = (w == sum) ? 3 : 5;
        default: ;
      endcase
    end
    exp_status = (ph == 3) ? 1 : (ph == 4) ? 2 : (ph == 5) ? 3 : 0;
    exp_cnt    = cnt;
  endfunction

  task automatic send(input int i, input logic [7:0] b);
    bt[i] = b;
    bv[i] = 1'b1;
    @(negedge clk);
    bv[i] = 1'b0;
  endtask

  task automatic run_stream(input int i, input bit gaps);
    wq.delete();
    foreach (stim[k]) begin
      send(i, stim[k]);
      if (gaps && ($urandom_range(0, 3) == 0)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic rearm(input int i);
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
    check("rearm_flags", {dn[i], ov[i], ce[i], lod[i]}, 4'b0001);
    check("rearm_count", wcn[i], 0);
  endtask

  task automatic compare_model(input int i);
    model(i);
    check("rnd_nwr", wq.size(), exp_w.size());
    foreach (wq[k]) begin
      if (k < exp_w.size()) begin
        check("rnd_waddr", wq[k].addr, k);
        check("rnd_wdata", wq[k].data, exp_w[k]);
      end
    end
    check("rnd_flags", {dn[i], ov[i], ce[i], lod[i]}, flags_of(exp_status));
    check("rnd_count", wcn[i], exp_cnt);
  endtask

  typedef struct {
    int           inst;
    int           n;
    logic [255:0] b;      // bytes left-aligned, first byte in the MSBs
    int           nw;
    logic [31:0]  last;
    logic [3:0]   flags;  // {done, overflow, cksum_err, loading}
    int           cnt;
  } vec_t;

  vec_t        vt[11];
  logic [255:0] vb;
  int          inst, len;
  logic [31:0] w, s;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin bt[i] = 8'h00; bv[i] = 1'b0; st[i] = 1'b0; end

    vt[0]  = '{0, 16, {128'h00000002_00000001_00000002_00000003, 128'h0}, 2, 32'h2, 4'b1000, 2};
    vt[1]  = '{0, 16, {128'h00000002_00000001_00000002_00000004, 128'h0}, 2, 32'h2, 4'b0010, 2};
    vt[2]  = '{0, 4,  {32'h00000009, 224'h0},                            0, 32'h0, 4'b0100, 0};
    vt[3]  = '{0, 8,  {64'h0, 192'h0},                                   0, 32'h0, 4'b1000, 0};
    vt[4]  = '{0, 16, {128'h00000002_FFFFFFFF_00000002_00000001, 128'h0}, 2, 32'h2, 4'b1000, 2};
    vt[5]  = '{1, 8,  {64'h12345678_FFFFFFFF, 192'h0},                   1, 32'h12345678, 4'b1000, 1};
    vt[6]  = '{1, 20, {160'h00000001_00000002_00000003_00000004_00000005, 96'h0}, 4, 32'h4, 4'b0100, 4};
    vt[7]  = '{1, 20, {160'h00000001_00000002_00000003_00000004_FFFFFFFF, 96'h0}, 4, 32'h4, 4'b1000, 4};
    vt[8]  = '{1, 4,  {32'hFFFFFFFF, 224'h0},                            0, 32'h0, 4'b1000, 0};
    vt[9]  = '{2, 4,  {32'hAABB_FFFF, 224'h0},                           1, 32'h0000BBAA, 4'b1000, 1};
    vt[10] = '{2, 6,  {48'h3412_FFFE_FFFF, 208'h0},                      2, 32'h0000FEFF, 4'b1000, 2};

    // Reset values, both while held and right after release.
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_flags", {wen[i], dn[i], ov[i], ce[i], lod[i]}, 5'b00001);
      check("rst_vals", {wad[i], wdt[i]}, 64'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) check("rst_count", wcn[i], 0);

    // Table-driven vectors.
    for (int v = 0; v < 11; v++) begin
      stim.delete();
      vb = vt[v].b;
      for (int k = 0; k < vt[v].n; k++) stim.push_back(vb[255-8*k -: 8]);
      run_stream(vt[v].inst, 1'b0);
      check("tbl_nwr", wq.size(), vt[v].nw);
      foreach (wq[k]) check("tbl_waddr", wq[k].addr, k);
      if (wq.size() > 0) check("tbl_last", wq[wq.size()-1].data, vt[v].last);
      check("tbl_flags", {dn[vt[v].inst], ov[vt[v].inst], ce[vt[v].inst], lod[vt[v].inst]}, vt[v].flags);
      check("tbl_count", wcn[vt[v].inst], vt[v].cnt);
      rearm(vt[v].inst);
    end

    // done/loading change exactly one cycle after the deciding byte.
    for (int k = 0; k < 7; k++) send(0, 8'h00);
    check("lat_before", {dn[0], lod[0]}, 2'b01);
    send(0, 8'h00);
    check("lat_after", {dn[0], lod[0]}, 2'b10);
    rearm(0);

    // Write strobe timing and single-cycle width.
    send(1, 8'h12); send(1, 8'h34); send(1, 8'h56);
    check("wen_early", wen[1], 1'b0);
    send(1, 8'h78);
    check("wen_pulse", {wen[1], wad[1], wdt[1], wcn[1]}, {1'b1, 32'h0, 32'h12345678, 32'h1});
    @(negedge clk);
    check("wen_width", wen[1], 1'b0);
    for (int k = 0; k < 4; k++) send(1, 8'hFF);
    check("mrk_done", dn[1], 1'b1);

    // Re-arm together with a byte: the byte is dropped.
    bt[1] = 8'h12; bv[1] = 1'b1; st[1] = 1'b1;
    @(negedge clk);
    bv[1] = 1'b0; st[1] = 1'b0;
    stim.delete();
    push32(32'h3456789A); push32(32'hFFFFFFFF);
    run_stream(1, 1'b0);
    check("drop_nwr", wq.size(), 1);
    if (wq.size() > 0) check("drop_data", wq[0].data, 32'h3456789A);
    rearm(1);

    // start_i during a load is ignored.
    stim.delete();
    push32(32'h1);
    run_stream(0, 1'b0);
    send(0, 8'h00); send(0, 8'h00);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    send(0, 8'h00); send(0, 8'h05);
    stim.delete();
    push32(32'h5);
    run_stream(0, 1'b0);
    check("ign_start", {dn[0], ov[0], ce[0], wcn[0]}, {3'b100, 32'h1});
    rearm(0);

    // Asynchronous reset in the middle of a word.
    stim.delete();
    push32(32'hAABBCCDD);
    run_stream(1, 1'b0);
    check("pre_rst_cnt", wcn[1], 1);
    send(1, 8'h11); send(1, 8'h22);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {wen[1], lod[1], dn[1], wad[1], wdt[1], wcn[1]}, {3'b010, 96'h0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stim.delete();
    push32(32'h11223344); push32(32'hFFFFFFFF);
    run_stream(1, 1'b0);
    check("post_rst_nwr", wq.size(), 1);
    if (wq.size() > 0) check("post_rst_wr", {wq[0].addr, wq[0].data}, {32'h0, 32'h11223344});
    rearm(1);

    // Randomised streams against the reference model.
    for (int it = 0; it < 36; it++) begin
      inst = int'($urandom_range(0, 2));
      stim.delete();
      if (inst == 0) begin
        len = int'($urandom_range(0, 9));
        push32(32'(len));
        s = 32'h0;
        if (len <= 8) begin
          for (int j = 0; j < len; j++) begin
            w = $urandom;
            if ($urandom_range(0, 7) == 0) w = 32'h0;
            push32(w);
            s = s + w;
          end
          if ($urandom_range(0, 1) == 1) push32(s);
          else                           push32(s ^ (32'h1 << $urandom_range(0, 31)));
        end
      end else begin
        len = int'($urandom_range(0, (inst == 1) ? 6 : 18));
        for (int j = 0; j < len * ((inst == 1) ? 4 : 2); j++) stim.push_back(8'($urandom));
        for (int j = 0; j < ((inst == 1) ? 4 : 2); j++) stim.push_back(8'hFF);
      end
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) stim.push_back(8'($urandom));
      run_stream(inst, 1'b1);
      compare_model(inst);
      rearm(inst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
